mul_unit: RTL and testbench

- Iterative radix-2 shift-add multiplier for the LEGv8 execute path. It sits directly downstream of the register file.
- Consumes rd1/rd2 operands and produces a write-back value plus a destination tag that drive the register file's wd3/wa3/we3.
- Implements MUL (low 64 bits), UMULH (unsigned high 64 bits) and SMULH (signed high 64 bits).
- Multi-cycle, with a start/busy/done handshake and a flush for pipeline squash.

---
 rtl/mul_pkg.sv | 33 +++
 rtl/mul_datapath.sv | 95 +++++++++
 rtl/mul_unit.sv | 131 +++++++++++++
 tb/tb_mul_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the iterative shift-add multiplier (mul_unit).
//   op_e     : operation encoding seen on the op port (2'b11 is reserved and
//              is handled exactly like MUL_LO)
//   state_e  : control FSM states
//   XZR      : architectural zero register, never written back
//   is_high_half() : tells whether an op returns the upper product half
// ---------------------------------------------------------------------------
package mul_pkg;

   typedef enum logic [1:0] {
      MUL_LO = 2'b00,
      UMULH  = 2'b01,
      SMULH  = 2'b10
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_e;

   localparam logic [4:0] XZR = 5'd31;

   // UMULH and SMULH deliver the upper half; MUL and the reserved code
   // deliver the lower half.
   function automatic logic is_high_half(input logic [1:0] op_code);
      return (op_code == UMULH) || (op_code == SMULH);
   endfunction

endpackage

// File: rtl/mul_datapath.sv
// ---------------------------------------------------------------------------
// mul_datapath
// Arithmetic half of the multiplier: operand magnitude capture, the 2N-bit
// product accumulator with its add/shift step, the final conditional negate
// and the result register.  Sequencing comes entirely from mul_unit.
//
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset, clears every register
//   load   : capture operands (accept edge); product is cleared
//   step   : perform one radix-2 add/shift iteration
//   fix    : apply sign correction and load the result register
//   op     : operation code, sampled together with load
//   a, b   : operands, sampled together with load
//   result : selected product half, changes only on a fix edge or reset
// ---------------------------------------------------------------------------
module mul_datapath
   import mul_pkg::*;
#(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         step,
   input  logic         fix,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] result
);

   logic [N-1:0]   mcand_q;
   logic [N-1:0]   mplier_q;
   logic [2*N-1:0] prod_q;
   logic           neg_q;
   logic           hi_q;

   logic           is_signed;
   logic [N-1:0]   a_mag;
   logic [N-1:0]   b_mag;
   logic [N-1:0]   addend;
   logic [N:0]     sum;
   logic [2*N-1:0] shifted;
   logic [2*N-1:0] fixed;

   // Operand conditioning for the accept edge.  SMULH works on magnitudes
   // and remembers the sign separately; the magnitude of the most negative
   // value is 2^(N-1), which still fits in N unsigned bits, so plain
   // negation is safe here.
   always_comb begin
      is_signed = (op == SMULH);
      a_mag     = (is_signed && a[N-1]) ? -a : a;
      b_mag     = (is_signed && b[N-1]) ? -b : b;
   end

   // One iteration: add the multiplicand into the upper half when the
   // current multiplier bit is set, keeping the carry as an extra bit, then
   // shift the (carry, product) pair right by one.  After N iterations the
   // full unsigned 2N-bit product sits in prod_q.
   always_comb begin
      addend  = mplier_q[0] ? mcand_q : '0;
      sum     = {1'b0, prod_q[2*N-1:N]} + {1'b0, addend};
      shifted = {sum, prod_q[N-1:1]};
      fixed   = neg_q ? -prod_q : prod_q;
   end

   // Register bank.  load, step and fix are mutually exclusive by
   // construction in the controller; the priority order here only matters
   // for robustness.  result is deliberately left alone on load so the
   // previous value stays visible until the new one is ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         neg_q    <= 1'b0;
         hi_q     <= 1'b0;
         result   <= '0;
      end else if (load) begin
         mcand_q  <= a_mag;
         mplier_q <= b_mag;
         prod_q   <= '0;
         neg_q    <= is_signed && (a[N-1] ^ b[N-1]);
         hi_q     <= is_high_half(op);
      end else if (step) begin
         prod_q   <= shifted;
         mplier_q <= mplier_q >> 1;
      end else if (fix) begin
         prod_q   <= fixed;
         result   <= hi_q ? fixed[2*N-1:N] : fixed[N-1:0];
      end
   end

endmodule

// File: rtl/mul_unit.sv
// ---------------------------------------------------------------------------
// mul_unit
// Iterative radix-2 shift-add multiplier for the LEGv8 execute path.
// Implements MUL (low half), UMULH (unsigned high half) and SMULH (signed
// high half) with a start/busy/done handshake and a pipeline flush.
// The write-back outputs drive the register file's wd3/wa3/we3 directly.
//
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   start  : request, accepted only in IDLE or DONE and only without flush
//   flush  : squash any in-flight operation (wins over start)
//   op     : 00 MUL, 01 UMULH, 10 SMULH, 11 treated as MUL
//   a, b   : operands from rd1/rd2
//   wa_in  : destination register of the operation
//   busy   : high while iterating (RUN) or correcting the sign (FIX)
//   done   : single-cycle pulse, result valid
//   result : selected product half, stable until the next result load
//   wa_out : captured destination tag
//   we_out : write enable, suppressed for XZR
//
// Timing: accept edge, then N RUN edges, then one FIX edge; done is high in
// the cycle that follows, independent of op and operand values.
// ---------------------------------------------------------------------------
module mul_unit
   import mul_pkg::*;
#(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         flush,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [4:0]   wa_in,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic [4:0]   wa_out,
   output logic         we_out
);

   localparam int            CW       = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   state_e        state_q;
   state_e        state_d;
   logic [CW-1:0] cnt_q;
   logic [4:0]    wa_q;
   logic          accept;
   logic          step_en;
   logic          fix_en;

   // Handshake qualifiers.  A request is only taken when the unit is free
   // (IDLE, or DONE for back-to-back issue) and the pipeline is not being
   // squashed on the same edge.  A flush also suppresses the step and fix
   // strobes so the datapath, and in particular result, is left untouched.
   always_comb begin
      accept  = start && !flush && ((state_q == IDLE) || (state_q == DONE));
      step_en = (state_q == RUN) && !flush;
      fix_en  = (state_q == FIX) && !flush;
   end

   // Next-state logic.  RUN leaves on the edge where the counter steps from
   // 1 to 0, which gives exactly N iterations after the accept edge.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (cnt_q == CNT_LAST) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Iteration counter and destination tag.  Both are captured only on an
   // accepted request, so a start pulse while busy cannot disturb them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         wa_q  <= '0;
      end else if (accept) begin
         cnt_q <= CNT_INIT;
         wa_q  <= wa_in;
      end else if (step_en) begin
         cnt_q <= cnt_q - CNT_LAST;
      end
   end

   // Arithmetic datapath, sequenced by the strobes above.
   mul_datapath #(
      .N (N)
   ) u_datapath (
      .clk    (clk),
      .reset  (reset),
      .load   (accept),
      .step   (step_en),
      .fix    (fix_en),
      .op     (op),
      .a      (a),
      .b      (b),
      .result (result)
   );

   // Status and write-back outputs decode straight from the state register,
   // so an asynchronous reset clears them immediately.
   always_comb begin
      busy   = (state_q == RUN) || (state_q == FIX);
      done   = (state_q == DONE);
      wa_out = wa_q;
      we_out = done && (wa_q != XZR);
   end

endmodule

// File: tb/tb_mul_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_unit
// Directed bench for mul_unit.  Each issued operation pushes its expected
// write-back onto a scoreboard queue; the entry is popped and compared when
// done rises.  Expected values come from constants or from a 2N-bit
// reference multiply.
// ---------------------------------------------------------------------------
module tb_mul_unit;
   import mul_pkg::*;

   localparam int N   = 64;
   localparam int LAT = N + 1;
   localparam int TMO = 200;

   typedef struct {
      logic [N-1:0] res;
      logic [4:0]   wa;
      logic         we;
   } exp_t;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [1:0]   op    = 2'b00;
   logic [N-1:0] a     = '0;
   logic [N-1:0] b     = '0;
   logic [4:0]   wa_in = '0;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic [4:0]   wa_out;
   logic         we_out;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;

   mul_unit #(
      .N (N)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .flush  (flush),
      .op     (op),
      .a      (a),
      .b      (b),
      .wa_in  (wa_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .wa_out (wa_out),
      .we_out (we_out)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Reference product: full 2N-bit multiply of zero- or sign-extended
   // operands, then the half the op asks for.
   function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] x,
                                          input logic [N-1:0] y);
      logic [2*N-1:0] xe;
      logic [2*N-1:0] ye;
      logic [2*N-1:0] p;
      if (o == 2'b10) begin
         xe = {{N{x[N-1]}}, x};
         ye = {{N{y[N-1]}}, y};
      end else begin
         xe = {{N{1'b0}}, x};
         ye = {{N{1'b0}}, y};
      end
      p = xe * ye;
      return ((o == 2'b01) || (o == 2'b10)) ? p[2*N-1:N] : p[N-1:0];
   endfunction

   // Single comparison point.
   task automatic checkVal(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Issue one request on the next edge and record its expected write-back.
   // Returns in the cycle after the accept edge.
   task automatic applyStimulus(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                                input logic [4:0] w, input logic [N-1:0] exp_res);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      wa_in = w;
      e.res = exp_res;
      e.wa  = w;
      e.we  = (w != XZR);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for done, checking latency and busy duration, then pop
   // the scoreboard and compare the write-back.  Leaves the bench in the
   // done cycle.
   task automatic checkOutput(input string tag, input int exp_lat, output int lat);
      int   cycles      = 0;
      int   busy_cycles = 0;
      exp_t e;
      while (done !== 1'b1 && cycles < TMO) begin
         if (busy === 1'b1) busy_cycles++;
         @(negedge clk);
         cycles++;
      end
      lat = cycles;
      checkVal({tag, "/done"}, N'(done), N'(1));
      checkVal({tag, "/latency"}, N'(cycles), N'(exp_lat));
      checkVal({tag, "/busy_cycles"}, N'(busy_cycles), N'(exp_lat));
      checkVal({tag, "/sb_pending"}, N'(sb.size() > 0), N'(1));
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkVal({tag, "/result"}, result, e.res);
         checkVal({tag, "/wa_out"}, N'(wa_out), N'(e.wa));
         checkVal({tag, "/we_out"}, N'(we_out), N'(e.we));
      end
   endtask

   // Watch for n cycles and report whether done ever rose.
   task automatic watchNoDone(input int n, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
   endtask

   // Safety net in case the stimulus itself stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence.
   initial begin
      int           lat;
      logic         seen;
      logic [N-1:0] held;
      exp_t         e;

      // Reset values.
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      checkVal("rst/busy", N'(busy), N'(0));
      checkVal("rst/done", N'(done), N'(0));
      checkVal("rst/result", result, '0);
      checkVal("rst/wa_out", N'(wa_out), N'(0));
      checkVal("rst/we_out", N'(we_out), N'(0));
      reset = 1'b1;

      // Basic MUL, then confirm done is a single-cycle pulse.
      applyStimulus(2'b00, 64'd6, 64'd7, 5'd5, 64'd42);
      checkOutput("mul_6x7", LAT, lat);
      @(negedge clk);
      checkVal("mul_6x7/done_pulse", N'(done), N'(0));
      checkVal("mul_6x7/idle_busy", N'(busy), N'(0));

      // Unsigned high and low halves of the same product.
      applyStimulus(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'd1);
      checkOutput("umulh_max_x2", LAT, lat);
      applyStimulus(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE);
      checkOutput("mul_max_x2", LAT, lat);

      // Signed results.
      applyStimulus(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("smulh_m1x1", LAT, lat);
      applyStimulus(2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd11, 64'hFFFF_FFFF_FFFF_FFF1);
      checkOutput("mul_m3x5", LAT, lat);
      applyStimulus(2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd12,
                    64'h4000_0000_0000_0000);
      checkOutput("smulh_min_min", LAT, lat);

      // XZR destination suppresses the write enable.
      applyStimulus(2'b00, 64'd9, 64'd9, 5'd31, 64'd81);
      checkOutput("mul_xzr", LAT, lat);

      // Reserved op code behaves as MUL.
      applyStimulus(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFFE);
      checkOutput("op11_as_mul", LAT, lat);

      // A few random operations against the reference model.
      for (int i = 0; i < 4; i++) begin
         logic [1:0]   ro;
         logic [N-1:0] rx;
         logic [N-1:0] ry;
         ro = 2'($urandom_range(0, 3));
         rx = {$urandom, $urandom};
         ry = {$urandom, $urandom};
         applyStimulus(ro, rx, ry, 5'(i + 1), model(ro, rx, ry));
         checkOutput("random", LAT, lat);
      end

      // start re-pulsed while busy is ignored.
      applyStimulus(2'b00, 64'd11, 64'd13, 5'd7, 64'd143);
      repeat (9) @(negedge clk);
      start = 1'b1;
      op    = 2'b10;
      a     = 64'd99;
      b     = 64'd99;
      wa_in = 5'd2;
      @(negedge clk);
      start = 1'b0;
      checkOutput("repulse", LAT - 10, lat);

      // Flush mid-RUN: no done, result untouched.
      @(negedge clk);
      start = 1'b1;
      op    = 2'b01;
      a     = 64'hFFFF_0000_FFFF_0000;
      b     = 64'h1234_5678_9ABC_DEF0;
      wa_in = 5'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkVal("flush/busy", N'(busy), N'(0));
      checkVal("flush/done", N'(done), N'(0));
      watchNoDone(80, seen);
      checkVal("flush/no_done", N'(seen), N'(0));
      checkVal("flush/result_held", result, 64'd143);

      // start together with flush in IDLE is not accepted.
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      op    = 2'b00;
      a     = 64'd5;
      b     = 64'd5;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      checkVal("start_flush/busy", N'(busy), N'(0));
      watchNoDone(80, seen);
      checkVal("start_flush/no_done", N'(seen), N'(0));
      checkVal("start_flush/result_held", result, 64'd143);

      // Back-to-back issue from DONE.
      applyStimulus(2'b00, 64'd2, 64'd3, 5'd4, 64'd6);
      checkOutput("b2b_first", LAT, lat);
      start = 1'b1;
      op    = 2'b01;
      a     = 64'hFFFF_FFFF_FFFF_FFFF;
      b     = 64'hFFFF_FFFF_FFFF_FFFF;
      wa_in = 5'd8;
      e.res = 64'hFFFF_FFFF_FFFF_FFFE;
      e.wa  = 5'd8;
      e.we  = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      checkVal("b2b/gap_done", N'(done), N'(0));
      checkOutput("b2b_second", LAT, lat);
      checkVal("b2b/done_spacing", N'(lat + 1), N'(N + 2));

      // Reset in the middle of RUN clears outputs immediately.
      held = result;
      checkVal("pre_reset/result_nonzero", N'(held != '0), N'(1));
      @(negedge clk);
      start = 1'b1;
      op    = 2'b00;
      a     = 64'd1000;
      b     = 64'd1000;
      wa_in = 5'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b0;
      #1;
      checkVal("midreset/busy", N'(busy), N'(0));
      checkVal("midreset/done", N'(done), N'(0));
      checkVal("midreset/result", result, '0);
      checkVal("midreset/we_out", N'(we_out), N'(0));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      watchNoDone(80, seen);
      checkVal("midreset/no_done", N'(seen), N'(0));
      checkVal("sb_drained", N'(sb.size()), N'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
